// File: rtl/oled_pkg.sv
// Shared geometry, field widths and state encoding for the OLED text-line arbiter.
package oled_pkg;

    localparam int unsigned OLED_PAGES = 8;
    localparam int unsigned OLED_COLS  = 16;
    localparam int unsigned PAGE_W     = $clog2(OLED_PAGES);
    localparam int unsigned COL_W      = $clog2(OLED_COLS);
    localparam int unsigned LEN_W      = 5;
    localparam int unsigned CHAR_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_e;

    // Characters that still fit on the line from col onward; 6-bit math so col + len cannot wrap.
    function automatic logic [LEN_W-1:0] clamp_len(
        input logic [COL_W-1:0] col,
        input logic [LEN_W-1:0] len,
        input int unsigned      cols
    );
        logic [5:0] room;
        logic [5:0] len6;
        if (6'(col) >= 6'(cols)) begin
            return '0;
        end
        room = 6'(cols) - 6'(col);
        len6 = 6'(len);
        return (len6 < room) ? len : LEN_W'(room);
    endfunction

endpackage

// File: rtl/oled_rr_pick.sv
// Round-robin picker: rotate requests down by the pointer, take the lowest set bit, rotate back.
module oled_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid_c,
    output logic [IDX_W-1:0]   idx_c
);

    localparam int unsigned SUM_W = IDX_W + 1;

    logic [NUM_REQ-1:0] rot;
    logic [IDX_W-1:0]   off;
    logic [SUM_W-1:0]   sum;

    always_comb begin
        rot     = NUM_REQ'({req, req} >> ptr);
        valid_c = |rot;
        off     = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
        sum = SUM_W'(off) + SUM_W'(ptr);
        if (sum >= SUM_W'(NUM_REQ)) begin
            sum = sum - SUM_W'(NUM_REQ);
        end
        idx_c = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/oled_text_arbiter.sv
// Round-robin arbiter sharing one OLED text-line writer between NUM_REQ clients,
// with geometry clamping, zero-length reject and a watchdog on the writer.
module oled_text_arbiter
    import oled_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_CHARS = 16,
    parameter logic [23:0] TIMEOUT   = 24'd2_000_000
) (
    input  logic                              sys_clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [PAGE_W*NUM_REQ-1:0]         req_page,
    input  logic [COL_W*NUM_REQ-1:0]          req_col,
    input  logic [LEN_W*NUM_REQ-1:0]          req_len,
    input  logic [CHAR_W*MAX_CHARS*NUM_REQ-1:0] req_text,
    output logic [NUM_REQ-1:0]                ack,
    output logic                              err_timeout,
    output logic                              busy,
    input  logic                              wr_ready,
    output logic                              wr_start,
    output logic [PAGE_W-1:0]                 wr_page,
    output logic [COL_W-1:0]                  wr_col,
    output logic [LEN_W-1:0]                  wr_len,
    output logic [CHAR_W*MAX_CHARS-1:0]       wr_text,
    input  logic                              wr_done
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TEXT_W = CHAR_W * MAX_CHARS;
    localparam int unsigned WD_W   = 24;

    arb_state_e         state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   nxt_ptr;
    logic [WD_W-1:0]    wdog;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [PAGE_W-1:0]  cand_page;
    logic [COL_W-1:0]   cand_col;
    logic [LEN_W-1:0]   cand_len;
    logic [TEXT_W-1:0]  cand_text;

    oled_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .valid_c (pick_valid),
        .idx_c   (pick_idx)
    );

    // Payload of the current round-robin candidate, length already clamped to the line.
    always_comb begin
        cand_page = req_page[32'(pick_idx) * PAGE_W +: PAGE_W];
        cand_col  = req_col[32'(pick_idx) * COL_W +: COL_W];
        cand_len  = clamp_len(cand_col, req_len[32'(pick_idx) * LEN_W +: LEN_W], MAX_CHARS);
        cand_text = req_text[32'(pick_idx) * TEXT_W +: TEXT_W];
        nxt_ptr   = (32'(winner) == NUM_REQ - 1) ? '0 : winner + IDX_W'(1);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            winner      <= '0;
            wdog        <= '0;
            ack         <= '0;
            err_timeout <= 1'b0;
            busy        <= 1'b0;
            wr_start    <= 1'b0;
            wr_page     <= '0;
            wr_col      <= '0;
            wr_len      <= '0;
            wr_text     <= '0;
        end else begin
            wr_start <= 1'b0;
            ack      <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        winner  <= pick_idx;
                        wr_page <= cand_page;
                        wr_col  <= cand_col;
                        wr_len  <= cand_len;
                        wr_text <= cand_text;
                        busy    <= 1'b1;
                        // Nothing fits on the line: reject without touching the writer.
                        if (cand_len == '0) begin
                            ack   <= NUM_REQ'(1) << pick_idx;
                            state <= ST_ACK;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (wr_ready) begin
                        wr_start <= 1'b1;
                        wdog     <= '0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wr_done) begin
                        ack   <= NUM_REQ'(1) << winner;
                        state <= ST_ACK;
                    end else if (wdog == TIMEOUT - 24'd1) begin
                        err_timeout <= 1'b1;
                        ack         <= NUM_REQ'(1) << winner;
                        state       <= ST_ACK;
                    end else begin
                        wdog <= wdog + 24'd1;
                    end
                end
                ST_ACK: begin
                    ptr   <= nxt_ptr;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oled_text_arbiter.sv
// Directed bench for oled_text_arbiter: scoreboard of expected writer commands and acks.
module tb_oled_text_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned MC = 16;
    localparam int unsigned TW = 8 * MC;

    logic            sys_clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [3*N-1:0]  req_page;
    logic [4*N-1:0]  req_col;
    logic [5*N-1:0]  req_len;
    logic [TW*N-1:0] req_text;
    logic [N-1:0]    ack;
    logic            err_timeout;
    logic            busy;
    logic            wr_ready;
    logic            wr_start;
    logic [2:0]      wr_page;
    logic [3:0]      wr_col;
    logic [4:0]      wr_len;
    logic [TW-1:0]   wr_text;
    logic            wr_done;

    typedef struct packed {
        logic [2:0]    page;
        logic [3:0]    col;
        logic [4:0]    len;
        logic [TW-1:0] text;
    } cmd_t;

    cmd_t exp_cmd_q[$];
    int   exp_ack_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    cmd_t mon_c;
    int   mon_a;
    logic bad;

    always #5 sys_clk = ~sys_clk;

    oled_text_arbiter #(
        .NUM_REQ   (N),
        .MAX_CHARS (MC),
        .TIMEOUT   (24'd50)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_page    (req_page),
        .req_col     (req_col),
        .req_len     (req_len),
        .req_text    (req_text),
        .ack         (ack),
        .err_timeout (err_timeout),
        .busy        (busy),
        .wr_ready    (wr_ready),
        .wr_start    (wr_start),
        .wr_page     (wr_page),
        .wr_col      (wr_col),
        .wr_len      (wr_len),
        .wr_text     (wr_text),
        .wr_done     (wr_done)
    );

    task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic set_client(input int i, input logic [2:0] p, input logic [3:0] c,
                              input logic [4:0] l, input logic [TW-1:0] t);
        req_page[3*i +: 3]  = p;
        req_col[4*i +: 4]   = c;
        req_len[5*i +: 5]   = l;
        req_text[TW*i +: TW] = t;
    endtask

    // Independent model of what the writer should receive for client i.
    function automatic cmd_t model(input int i);
        cmd_t c;
        int   room;
        int   l;
        c.page = req_page[3*i +: 3];
        c.col  = req_col[4*i +: 4];
        l      = int'(req_len[5*i +: 5]);
        room   = 16 - int'(c.col);
        c.len  = 5'((l < room) ? l : room);
        c.text = req_text[TW*i +: TW];
        return c;
    endfunction

    function automatic logic [TW-1:0] text_of(input int i);
        return {8'(8'h41 + i), {15{8'h2E}}};
    endfunction

    task automatic push(input int i);
        exp_cmd_q.push_back(model(i));
        exp_ack_q.push_back(i);
    endtask

    task automatic wait_start(input string tag);
        int k = 0;
        while (wr_start !== 1'b1 && k < 300) begin
            tick(1);
            k++;
        end
        chk(tag, TW'(wr_start), TW'(1'b1));
    endtask

    task automatic finish_xfer(input int i, input string tag);
        logic [N-1:0] oh = N'(1) << i;
        wr_done = 1'b1;
        tick(1);
        wr_done = 1'b0;
        chk({tag, "_ack"}, TW'(ack), TW'(oh));
        req[i] = 1'b0;
        tick(1);
    endtask

    task automatic serve(input int i, input string tag);
        wait_start({tag, "_start"});
        finish_xfer(i, tag);
    endtask

    // Scoreboard: every wr_start and every ack is matched against the expected queues.
    always @(negedge sys_clk) begin
        if (rst_n === 1'b1) begin
            if (wr_start === 1'b1) begin
                chk("cmd_expected", TW'(exp_cmd_q.size() != 0), TW'(1'b1));
                if (exp_cmd_q.size() != 0) begin
                    mon_c = exp_cmd_q.pop_front();
                    chk("sb_page", TW'(wr_page), TW'(mon_c.page));
                    chk("sb_col",  TW'(wr_col),  TW'(mon_c.col));
                    chk("sb_len",  TW'(wr_len),  TW'(mon_c.len));
                    chk("sb_text", wr_text, mon_c.text);
                end
            end
            if (ack !== '0) begin
                chk("ack_expected", TW'(exp_ack_q.size() != 0), TW'(1'b1));
                if (exp_ack_q.size() != 0) begin
                    mon_a = exp_ack_q.pop_front();
                    chk("sb_ack", TW'(ack), TW'(N'(1) << mon_a));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete in time");
        $fatal(1, "global timeout");
    end

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        req_page = '0;
        req_col  = '0;
        req_len  = '0;
        req_text = '0;
        wr_ready = 1'b1;
        wr_done  = 1'b0;
        tick(2);
        chk("rst_ack",   TW'(ack),         TW'(0));
        chk("rst_start", TW'(wr_start),    TW'(0));
        chk("rst_busy",  TW'(busy),        TW'(0));
        chk("rst_err",   TW'(err_timeout), TW'(0));
        chk("rst_page",  TW'(wr_page),     TW'(0));
        chk("rst_len",   TW'(wr_len),      TW'(0));
        chk("rst_text",  wr_text,          TW'(0));
        rst_n = 1'b1;
        tick(1);

        // Single request: two-cycle latency to wr_start, ack one cycle after wr_done.
        set_client(1, 3'd2, 4'd5, 5'd4, {"1.23", 96'h0});
        push(1);
        req[1] = 1'b1;
        tick(1);
        chk("t1_no_start", TW'(wr_start), TW'(0));
        chk("t1_busy",     TW'(busy),     TW'(1));
        tick(1);
        chk("t1_start", TW'(wr_start), TW'(1));
        chk("t1_page",  TW'(wr_page),  TW'(2));
        chk("t1_col",   TW'(wr_col),   TW'(5));
        chk("t1_len",   TW'(wr_len),   TW'(4));
        finish_xfer(1, "t1");
        chk("t1_idle",  TW'(busy), TW'(0));
        chk("t1_noack", TW'(ack),  TW'(0));

        // Round-robin from a fresh pointer with all four clients requesting.
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            set_client(i, 3'(i), 4'(i), 5'(i + 1), text_of(i));
            push(i);
        end
        req = 4'b1111;
        for (int i = 0; i < 4; i++) serve(i, "t2_rr");
        push(0);
        push(3);
        req[0] = 1'b1;
        req[3] = 1'b1;
        serve(0, "t2_p0");
        serve(3, "t2_p3");

        // Clamp at the right edge, then a zero-length reject.
        set_client(2, 3'd3, 4'd12, 5'd10, text_of(7));
        push(2);
        req[2] = 1'b1;
        wait_start("t3_clamp_start");
        chk("t3_clamp_len", TW'(wr_len), TW'(4));
        finish_xfer(2, "t3_clamp");
        set_client(3, 3'd1, 4'd15, 5'd0, text_of(8));
        exp_ack_q.push_back(3);
        req[3] = 1'b1;
        tick(1);
        chk("t3_rej_ack",   TW'(ack),      TW'(4'b1000));
        chk("t3_rej_start", TW'(wr_start), TW'(0));
        req[3] = 1'b0;
        tick(1);
        chk("t3_rej_idle",  TW'(busy),     TW'(0));

        // Writer not ready for 100 cycles; stray wr_done and input changes must be ignored.
        wr_ready = 1'b0;
        set_client(0, 3'd5, 4'd3, 5'd6, text_of(9));
        push(0);
        req[0] = 1'b1;
        tick(2);
        bad = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (wr_start !== 1'b0 || ack !== '0 || busy !== 1'b1) bad = 1'b1;
            if (k == 5) set_client(0, 3'd7, 4'd0, 5'd1, text_of(10));
            wr_done = (k == 10);
            tick(1);
        end
        wr_done = 1'b0;
        chk("t4_stall",      TW'(bad),     TW'(0));
        chk("t4_hold_page",  TW'(wr_page), TW'(5));
        chk("t4_hold_len",   TW'(wr_len),  TW'(6));
        wr_ready = 1'b1;
        tick(1);
        chk("t4_start",      TW'(wr_start), TW'(1));
        chk("t4_start_text", wr_text,       text_of(9));
        tick(1);
        chk("t4_one_pulse",  TW'(wr_start), TW'(0));
        finish_xfer(0, "t4");

        // Watchdog: no wr_done, abort 50 cycles after wr_start; later requests still served.
        set_client(1, 3'd4, 4'd2, 5'd3, text_of(11));
        push(1);
        req[1] = 1'b1;
        wait_start("t5_start");
        tick(49);
        chk("t5_err_early", TW'(err_timeout), TW'(0));
        chk("t5_ack_early", TW'(ack),         TW'(0));
        tick(1);
        chk("t5_err_set",   TW'(err_timeout), TW'(1));
        chk("t5_abort_ack", TW'(ack),         TW'(4'b0010));
        req[1] = 1'b0;
        tick(1);
        chk("t5_idle", TW'(busy), TW'(0));
        set_client(2, 3'd6, 4'd0, 5'd16, text_of(12));
        push(2);
        req[2] = 1'b1;
        serve(2, "t5_after");
        chk("t5_err_sticky", TW'(err_timeout), TW'(1));

        // Reset during WAIT: outputs clear immediately, pointer restarts at 0.
        set_client(3, 3'd4, 4'd8, 5'd8, text_of(13));
        exp_cmd_q.push_back(model(3));
        req[2] = 1'b1;
        req[3] = 1'b1;
        wait_start("t6_start");
        chk("t6_first_winner", TW'(wr_page), TW'(4));
        tick(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy",  TW'(busy),        TW'(0));
        chk("t6_rst_err",   TW'(err_timeout), TW'(0));
        chk("t6_rst_ack",   TW'(ack),         TW'(0));
        chk("t6_rst_page",  TW'(wr_page),     TW'(0));
        chk("t6_rst_col",   TW'(wr_col),      TW'(0));
        chk("t6_rst_len",   TW'(wr_len),      TW'(0));
        chk("t6_rst_text",  wr_text,          TW'(0));
        tick(1);
        rst_n = 1'b1;
        push(2);
        push(3);
        wait_start("t6_re_start");
        chk("t6_ptr0_winner", TW'(wr_page), TW'(6));
        finish_xfer(2, "t6_c2");
        serve(3, "t6_c3");

        tick(2);
        chk("end_cmd_q", TW'(exp_cmd_q.size()), TW'(0));
        chk("end_ack_q", TW'(exp_ack_q.size()), TW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
